// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard sequencer
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MC_BUSY  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam int          REG_ZERO  = 0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch adds offset to the already-incremented PC, hence the extra -4.
    function automatic logic [31:0] branch_offset(input logic [31:0] target,
                                                  input logic [31:0] pc);
        return target - pc - 32'd4;
    endfunction

endpackage

// File: rtl/ctrl_sat_counter.sv
// rtl/ctrl_sat_counter.sv - saturating event counter for performance debug
module ctrl_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use, multi-cycle EX and branch redirect sequencer
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_mc_start,
    input  logic              ex_br_taken,
    input  logic [31:0]       ex_target,
    input  logic [31:0]       fetch_pc,
    output logic              stall_out,
    output logic              jump_out,
    output logic [31:0]       offset_out,
    output logic              hold_id,
    output logic              bubble_ex,
    output logic              bubble_mem,
    output logic              mc_done,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int MC_CW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
    localparam logic [MC_CW-1:0] MC_LOAD = MC_CW'(MC_LATENCY - 2);

    state_t           state, state_nxt;
    logic [MC_CW-1:0] mc_cnt, mc_cnt_nxt;

    logic        load_use;
    logic        stall_c, jump_c, hold_c, bubble_ex_c, bubble_mem_c, mc_done_c;
    logic [31:0] offset_c;

    assign load_use = ex_mem_read && (ex_rd != REG_AW'(REG_ZERO)) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mc_cnt_nxt   = mc_cnt;
        stall_c      = 1'b0;
        jump_c       = 1'b0;
        offset_c     = 32'd0;
        hold_c       = 1'b0;
        bubble_ex_c  = 1'b0;
        bubble_mem_c = 1'b0;
        mc_done_c    = 1'b0;

        case (state)
            IDLE: begin
                // A taken branch outranks hazards: the dependent instr is wrong-path.
                if (ex_br_taken) begin
                    jump_c      = 1'b1;
                    offset_c    = branch_offset(ex_target, fetch_pc);
                    bubble_ex_c = 1'b1;
                    state_nxt   = REDIRECT;
                end else if (ex_mc_start) begin
                    stall_c      = 1'b1;
                    hold_c       = 1'b1;
                    bubble_mem_c = 1'b1;
                    mc_cnt_nxt   = MC_LOAD;
                    state_nxt    = MC_BUSY;
                end else if (load_use) begin
                    stall_c     = 1'b1;
                    bubble_ex_c = 1'b1;
                end
            end

            MC_BUSY: begin
                stall_c      = 1'b1;
                hold_c       = 1'b1;
                bubble_mem_c = 1'b1;
                if (mc_cnt == '0) begin
                    mc_done_c = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    mc_cnt_nxt = mc_cnt - MC_CW'(1);
                end
            end

            REDIRECT: begin
                // The bubble now in ID/EX cannot branch again, so only load-use matters.
                if (load_use) begin
                    stall_c     = 1'b1;
                    bubble_ex_c = 1'b1;
                end
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are forced quiet for the whole time reset is held.
    assign stall_out  = stall_c      & ~rst;
    assign jump_out   = jump_c       & ~rst;
    assign offset_out = rst ? 32'd0 : offset_c;
    assign hold_id    = hold_c       & ~rst;
    assign bubble_ex  = bubble_ex_c  & ~rst;
    assign bubble_mem = bubble_mem_c & ~rst;
    assign mc_done    = mc_done_c    & ~rst;
    assign busy       = (state != IDLE);

    ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_out),
        .count (stall_cnt)
    );

    ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (jump_out),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_mem_read, ex_mc_start, ex_br_taken;
    logic [31:0] ex_target, fetch_pc;

    logic        stall_out, jump_out, hold_id, bubble_ex, bubble_mem, mc_done, busy;
    logic [31:0] offset_out;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall, s_jump, s_hold, s_bex, s_bmem, s_done, s_busy;
    logic [31:0] s_offset;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_stalls = 0;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       used1;
        logic       used2;
        logic [4:0] rd;
        logic       mem_read;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .MC_LATENCY(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start),
        .ex_br_taken(ex_br_taken), .ex_target(ex_target), .fetch_pc(fetch_pc),
        .stall_out(stall_out), .jump_out(jump_out), .offset_out(offset_out),
        .hold_id(hold_id), .bubble_ex(bubble_ex), .bubble_mem(bubble_mem),
        .mc_done(mc_done), .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .MC_LATENCY(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start),
        .ex_br_taken(ex_br_taken), .ex_target(ex_target), .fetch_pc(fetch_pc),
        .stall_out(s_stall), .jump_out(s_jump), .offset_out(s_offset),
        .hold_id(s_hold), .bubble_ex(s_bex), .bubble_mem(s_bmem),
        .mc_done(s_done), .busy(s_busy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; ex_mc_start = 1'b0; ex_br_taken = 1'b0;
        ex_target = '0; fetch_pc = '0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1};
        vecs[1] = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[2] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1};
        vecs[3] = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0};
        vecs[4] = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0};
        vecs[5] = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1};
        vecs[6] = '{5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0};

        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        check("reset_stall", {31'd0, stall_out}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        rst = 1'b0;

        // Load-use table, all evaluated from IDLE
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_rs1_used = vecs[i].used1; id_rs2_used = vecs[i].used2;
            ex_rd = vecs[i].rd; ex_mem_read = vecs[i].mem_read;
            #3;
            check($sformatf("vec%0d_stall", i), {31'd0, stall_out}, {31'd0, vecs[i].exp_stall});
            check($sformatf("vec%0d_bubble_ex", i), {31'd0, bubble_ex}, {31'd0, vecs[i].exp_stall});
            check($sformatf("vec%0d_hold", i), {31'd0, hold_id}, 32'd0);
            if (vecs[i].exp_stall) exp_stalls++;
        end
        next_cycle();
        idle_inputs();
        #3;
        check("table_stall_cnt", {16'd0, stall_cnt}, exp_stalls);
        check("table_stall_quiet", {31'd0, stall_out}, 32'd0);

        // Branch redirect, branch held into REDIRECT with a load-use there
        next_cycle();
        fetch_pc = 32'h20; ex_target = 32'h08; ex_br_taken = 1'b1;
        #3;
        check("br_jump", {31'd0, jump_out}, 32'd1);
        check("br_offset", offset_out, 32'hFFFF_FFE4);
        check("br_bubble_ex", {31'd0, bubble_ex}, 32'd1);
        check("br_stall", {31'd0, stall_out}, 32'd0);
        next_cycle();
        set_load_use();
        #3;
        check("redir_jump", {31'd0, jump_out}, 32'd0);
        check("redir_offset", offset_out, 32'd0);
        check("redir_busy", {31'd0, busy}, 32'd1);
        check("redir_lu_stall", {31'd0, stall_out}, 32'd1);
        check("redir_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        exp_stalls++;
        next_cycle();
        idle_inputs();
        #3;
        check("post_redir_busy", {31'd0, busy}, 32'd0);

        // Branch and load-use in the same cycle
        next_cycle();
        set_load_use();
        ex_br_taken = 1'b1; fetch_pc = 32'h100; ex_target = 32'h200;
        #3;
        check("sim_jump", {31'd0, jump_out}, 32'd1);
        check("sim_stall", {31'd0, stall_out}, 32'd0);
        check("sim_offset", offset_out, 32'h0000_00FC);
        next_cycle();
        idle_inputs();
        #3;
        check("sim_redir_jump", {31'd0, jump_out}, 32'd0);
        next_cycle();
        #3;
        check("sim_flush_cnt", {16'd0, flush_cnt}, 32'd2);
        check("sim_busy", {31'd0, busy}, 32'd0);

        // Multi-cycle op, with a branch attempt ignored mid-op
        next_cycle();
        ex_mc_start = 1'b1;
        #3;
        check("mc0_stall", {31'd0, stall_out}, 32'd1);
        check("mc0_hold", {31'd0, hold_id}, 32'd1);
        check("mc0_bubble_mem", {31'd0, bubble_mem}, 32'd1);
        check("mc0_done", {31'd0, mc_done}, 32'd0);
        exp_stalls++;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            idle_inputs();
            ex_br_taken = (k == 1);
            #3;
            check($sformatf("mc%0d_stall", k), {31'd0, stall_out}, 32'd1);
            check($sformatf("mc%0d_jump", k), {31'd0, jump_out}, 32'd0);
            check($sformatf("mc%0d_done", k), {31'd0, mc_done}, (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("mc%0d_busy", k), {31'd0, busy}, 32'd1);
            exp_stalls++;
        end
        next_cycle();
        idle_inputs();
        #3;
        check("mc4_busy", {31'd0, busy}, 32'd0);
        check("mc4_stall", {31'd0, stall_out}, 32'd0);
        check("mc_stall_cnt", {16'd0, stall_cnt}, exp_stalls);
        check("mc_flush_cnt", {16'd0, flush_cnt}, 32'd2);

        // Reset asserted while MC_BUSY
        next_cycle();
        ex_mc_start = 1'b1;
        next_cycle();
        idle_inputs();
        #3;
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        check("rst_mid_stall", {31'd0, stall_out}, 32'd0);
        check("rst_mid_hold", {31'd0, hold_id}, 32'd0);
        check("rst_mid_bubble_mem", {31'd0, bubble_mem}, 32'd0);
        check("rst_mid_done", {31'd0, mc_done}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_mid_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        check("rst_mid_sat_cnt", {30'd0, s_stall_cnt}, 32'd0);
        rst = 1'b0;
        next_cycle();
        #3;
        check("rst_release_busy", {31'd0, busy}, 32'd0);

        // Saturation: five load-use stalls into a 2-bit counter
        for (int n = 0; n < 5; n++) begin
            next_cycle();
            set_load_use();
            #3;
            check($sformatf("sat%0d_stall", n), {31'd0, s_stall}, 32'd1);
        end
        next_cycle();
        idle_inputs();
        #3;
        check("sat_stall_cnt", {30'd0, s_stall_cnt}, 32'd3);
        check("wide_stall_cnt", {16'd0, stall_cnt}, 32'd5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
